// File: rtl/bch_pkg.sv
// Shared BCH(15,11) constants, FSM state encodings and GF(16) helper.
// Used by both the serial encoder and bch_decoder.
package bch_pkg;

   localparam int unsigned N     = 15;
   localparam int unsigned K     = 11;
   localparam int unsigned SYN_W = 4;

   // g(x) = x^4 + x + 1, low terms fed back when x^4 falls off
   localparam logic [SYN_W-1:0] GEN_FB = 4'b0011;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RECV   = 2'd1;
   localparam state_t ST_SEARCH = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   function automatic logic [SYN_W-1:0] gf16_mul_alpha(input logic [SYN_W-1:0] a);
      gf16_mul_alpha = {a[SYN_W-2:0], 1'b0} ^ (a[SYN_W-1] ? GEN_FB : 4'b0000);
   endfunction

endpackage

// File: rtl/bch_syndrome_lfsr.sv
// Serial syndrome divider r(x) mod g(x); with BCH_DEC_EXT_PARITY_EN defined
// it also accumulates overall parity of every received bit.
module bch_syndrome_lfsr
   import bch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic             bit_i,
`ifdef BCH_DEC_EXT_PARITY_EN
   input  logic             par_en_i,
   output logic             par_o,
`endif
   output logic [SYN_W-1:0] syn_o
);

   logic [SYN_W-1:0] syn_q, syn_d;

   always_comb begin
      syn_d = syn_q;
      if (load_i) begin
         syn_d = {3'b000, bit_i};
      end else if (shift_i) begin
         syn_d = gf16_mul_alpha(syn_q) ^ {3'b000, bit_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         syn_q <= '0;
      end else begin
         syn_q <= syn_d;
      end
   end

   assign syn_o = syn_q;

`ifdef BCH_DEC_EXT_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (load_i) begin
         par_d = bit_i;
      end else if (par_en_i) begin
         par_d = par_q ^ bit_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign par_o = par_q;
`endif

endmodule

// File: rtl/bch_decoder.sv
// Bit-serial BCH(15,11) single-error-correcting decoder with alpha-power search.
// Define BCH_DEC_EXT_PARITY_EN for the 16-bit extended code with double-error detection.
module bch_decoder
   import bch_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic             in_bit_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [K-1:0]     data_out_o,
   output logic             corrected_o,
   output logic             uncorrectable_o,
   output logic [3:0]       err_pos_o,
   output logic [CNT_W-1:0] corr_cnt_o
);

`ifdef BCH_DEC_EXT_PARITY_EN
   localparam int unsigned NBITS = N + 1;
`else
   localparam int unsigned NBITS = N;
`endif
   localparam int unsigned BCNT_W = 5;
   localparam logic [3:0]  NO_POS = 4'hF;

   state_t            state_q, state_d;
   logic [BCNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]      shift_q, shift_d;
   logic [SYN_W-1:0]  a_q, a_d;
   logic [3:0]        i_q, i_d;
   logic [3:0]        pos_q, pos_d;
   logic              hit_q, hit_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [K-1:0]      data_q, data_d;
   logic              corr_q, corr_d;
   logic              unc_q, unc_d;
   logic [3:0]        err_q, err_d;
   logic [CNT_W-1:0]  ccnt_q, ccnt_d;

   logic              accept_c;
   logic              load_c, shift_en_c;
   logic              hit_c, hit_now_c;
   logic [3:0]        pos_now_c;
   logic [N-1:0]      fixed_c;
   logic [SYN_W-1:0]  syn;
`ifdef BCH_DEC_EXT_PARITY_EN
   logic              par_en_c;
   logic              par;
`endif

   assign accept_c = in_valid_i && in_ready_q;

   bch_syndrome_lfsr u_syn (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_c),
      .shift_i  (shift_en_c),
      .bit_i    (in_bit_i),
`ifdef BCH_DEC_EXT_PARITY_EN
      .par_en_i (par_en_c),
      .par_o    (par),
`endif
      .syn_o    (syn)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      a_d         = a_q;
      i_d         = i_q;
      pos_d       = pos_q;
      hit_d       = hit_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      corr_d      = corr_q;
      unc_d       = unc_q;
      err_d       = err_q;
      ccnt_d      = ccnt_q;
      load_c      = 1'b0;
      shift_en_c  = 1'b0;
      hit_c       = 1'b0;
      hit_now_c   = hit_q;
      pos_now_c   = pos_q;
      fixed_c     = shift_q;
`ifdef BCH_DEC_EXT_PARITY_EN
      par_en_c    = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               load_c  = 1'b1;
               shift_d = N'(in_bit_i);
               cnt_d   = BCNT_W'(1);
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (accept_c) begin
               // The extension bit only feeds parity, never the syndrome
               shift_en_c = (cnt_q < BCNT_W'(N));
`ifdef BCH_DEC_EXT_PARITY_EN
               par_en_c   = 1'b1;
`endif
               if (shift_en_c) begin
                  shift_d = {shift_q[N-2:0], in_bit_i};
               end
               cnt_d = cnt_q + BCNT_W'(1);
               if (cnt_q == BCNT_W'(NBITS - 1)) begin
                  state_d    = ST_SEARCH;
                  in_ready_d = 1'b0;
                  a_d        = 4'b0001;
                  i_d        = 4'd0;
                  hit_d      = 1'b0;
                  pos_d      = NO_POS;
               end
            end
         end
         ST_SEARCH: begin
            hit_c     = (syn != '0) && (a_q == syn);
            hit_now_c = hit_q || hit_c;
            pos_now_c = hit_c ? i_q : pos_q;
            hit_d     = hit_now_c;
            pos_d     = pos_now_c;
            a_d       = gf16_mul_alpha(a_q);
            i_d       = i_q + 4'd1;
            fixed_c   = shift_q ^ (N'(1) << pos_now_c);
            if (i_q == 4'(N - 1)) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               data_d      = shift_q[N-1:N-K];
               corr_d      = 1'b0;
               unc_d       = 1'b0;
               err_d       = NO_POS;
`ifdef BCH_DEC_EXT_PARITY_EN
               if (hit_now_c && par) begin
                  data_d = fixed_c[N-1:N-K];
                  corr_d = 1'b1;
                  err_d  = pos_now_c;
               end else if (hit_now_c) begin
                  unc_d  = 1'b1;
               end else if (par) begin
                  corr_d = 1'b1;
               end
`else
               if (hit_now_c) begin
                  data_d = fixed_c[N-1:N-K];
                  corr_d = 1'b1;
                  err_d  = pos_now_c;
               end
`endif
               if (corr_d && (ccnt_q != '1)) begin
                  ccnt_d = ccnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         a_q         <= 4'b0001;
         i_q         <= '0;
         pos_q       <= NO_POS;
         hit_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         corr_q      <= 1'b0;
         unc_q       <= 1'b0;
         err_q       <= NO_POS;
         ccnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         a_q         <= a_d;
         i_q         <= i_d;
         pos_q       <= pos_d;
         hit_q       <= hit_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         corr_q      <= corr_d;
         unc_q       <= unc_d;
         err_q       <= err_d;
         ccnt_q      <= ccnt_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign data_out_o  = data_q;
   assign corrected_o = corr_q;
   assign err_pos_o   = err_q;
   assign corr_cnt_o  = ccnt_q;
`ifdef BCH_DEC_EXT_PARITY_EN
   assign uncorrectable_o = unc_q;
`else
   assign uncorrectable_o = 1'b0;
`endif

endmodule

// File: doc/bch_decoder.md
# bch_decoder

Bit-serial BCH(15,11) single-error-correcting decoder with generator g(x)=x^4+x+1. It is the receive-side counterpart of the team's systematic BCH(15,11) encoder. It accepts one codeword bit per handshake, computes the syndrome on the fly and locates any single error with a 15-cycle alpha-power search. It then presents the corrected 11-bit message with status flags on a valid/ready output.

## Interface
- CNT_W, 16, width of the saturating corrected-word counter
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  codeword bit; first bit is c14 (message MSB), last bit is c0 (or the extension bit, see Configuration)
- in_ready  out  1  decoder accepts a bit this cycle
- out_valid  out  1  decoded word available
- out_ready  in  1  consumer takes the word
- data_out  out  11  corrected message c14..c4
- corrected  out  1  one bit was flipped
- uncorrectable  out  1  double error detected (extended build only, else 0)
- err_pos  out  4  corrected bit index 0..14; 4'hF when no correction is made
- corr_cnt  out  CNT_W  count of words with corrected=1, saturating at all-ones

## Operation
- States: IDLE, RECV, SEARCH, DONE.
- IDLE: in_ready=1. The first accepted bit clears the syndrome, loads the shift register and moves the FSM to RECV.
- RECV: in_ready=1. On each accepted bit:
  - shift[14:0] <= {shift[13:0], in_bit}
  - s <= {s[2:0],1'b0} ^ (s[3] ? 4'b0011 : 4'b0000) ^ {3'b000, in_bit}
- Bit counter: after 15 bits (16 in the extended build) go to SEARCH. Gaps with in_valid=0 are allowed and do not advance the counter.
- SEARCH: in_ready=0. a is initialised to 4'b0001 and index i to 0. Each cycle:
  - if s!=0 and a==s, record i as the error position
  - a <= a*alpha (mod g)
  - i <= i+1
  - Always exactly 15 cycles. Every nonzero s matches exactly one i.
- DONE: in_ready=0, out_valid=1.
  - The recorded bit of the shift register is flipped before data_out is taken.
  - Outputs are held stable until out_valid && out_ready, then the FSM returns to IDLE.
- corr_cnt increments once per word with corrected=1, in the cycle that enters DONE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, data_out 0, corrected 0, uncorrectable 0, err_pos 4'hF, corr_cnt 0.
- Latency: if the last bit is accepted in cycle T, SEARCH occupies T+1..T+15 and out_valid rises in T+16.
- Throughput: at most one word per 15+15+1 cycles, plus any out_ready stall.
- No bit is accepted while out_valid=1, so back-pressure stalls the input.
- Reset asserted mid-word or mid-SEARCH discards all partial state. corr_cnt is also cleared.
- out_ready held high permanently: the handshake completes in the first DONE cycle and in_ready returns in the next cycle.

## Configuration
- BCH_DEC_EXT_PARITY_EN defined:
  - A 16th bit (overall even parity over c14..c0) follows c0, and the decoder also accumulates parity p.
  - s!=0 and p=1: single error, corrected as above.
  - s!=0 and p=0: uncorrectable=1, corrected=0, data_out is the uncorrected message, err_pos=4'hF.
  - s==0 and p=1: the error is in the parity bit; corrected=1, err_pos=4'hF, data unchanged.
- Undefined: 15-bit words, uncorrectable tied 0.

## Structure
- Package bch_pkg holds:
  - N=15, K=11
  - generator feedback constant 4'b0011
  - the state enum
  - a gf16_mul_alpha function
- The encoder also uses bch_pkg.
- Natural sub-module: bch_syndrome_lfsr (serial syndrome plus optional parity accumulator).

## Test plan
- Clean word: data 11'h001, codeword 15'h0013 -> data_out 11'h001, corrected 0, err_pos F, out_valid at T+16.
- Single error, LSB: received 15'h0012 -> s=4'b0001, err_pos 0, data_out 11'h001, corrected 1, corr_cnt 1.
- Single error, MSB: received 15'h4013 -> s=4'b1001, err_pos 14, data_out 11'h001.
- Input gaps and out_ready held low for 10 cycles -> outputs stable, in_ready 0 throughout, next word decodes correctly.
- Reset after 7 bits, then a fresh 15'h0013 -> clean decode, no contamination from the partial word.
- Extended build: flip bits 0 and 5 -> uncorrectable 1, corrected 0. Flip only the parity bit -> corrected 1, err_pos F.
